// File: rtl/lpc_pkg.sv
// Shared constants and types for the LPC analysis chain.
// The stage modules (autocorrelation, Levinson-Durbin, ifilter_control)
// import the same frame geometry and order from here.
package lpc_pkg;

   localparam int FRAME_LEN = 160;
   localparam int LPC_ORDER = 10;
   localparam int ADDR_W    = 8;
   localparam int CNT_W     = 16;

   typedef enum logic [2:0] {
      IDLE,
      ACORR,
      LEV,
      IFILT,
      DONE
   } lpc_state_e;

endpackage

// File: rtl/lpc_frame_sequencer_if.sv
// Bundle of sample-capture, buffer-bank and stage-handshake signals
// between the frame sequencer and its environment.
// master: the sequencer itself; slave: the sample front end and the stages.
interface lpc_frame_sequencer_if;
   import lpc_pkg::*;

   logic              sample_valid;
   logic              x_wen;
   logic [ADDR_W-1:0] x_waddr;
   logic              x_wbank;
   logic              x_rbank;
   logic              acorr_start;
   logic              acorr_done;
   logic              lev_start;
   logic              lev_done;
   logic              ifilter_reset;
   logic              ifilter_ready;
   logic              busy;
   logic              frame_done;
   logic [CNT_W-1:0]  frame_count;
   logic              overrun;
   logic              clear_overrun;
   logic              timeout;

   modport master (
      input  sample_valid, acorr_done, lev_done, ifilter_ready, clear_overrun,
      output x_wen, x_waddr, x_wbank, x_rbank, acorr_start, lev_start,
             ifilter_reset, busy, frame_done, frame_count, overrun, timeout
   );

   modport slave (
      output sample_valid, acorr_done, lev_done, ifilter_ready, clear_overrun,
      input  x_wen, x_waddr, x_wbank, x_rbank, acorr_start, lev_start,
             ifilter_reset, busy, frame_done, frame_count, overrun, timeout
   );

endinterface

// File: rtl/lpc_sample_writer.sv
// Write-side address generator for the ping-pong sample buffer.
// Counts accepted samples within a frame and flags the cycle in which
// the last sample of a frame is written (the bank toggle request).
module lpc_sample_writer
   import lpc_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   output logic              x_wen,
   output logic [ADDR_W-1:0] x_waddr,
   output logic              frame_full
);

   logic [ADDR_W-1:0] wr_cnt_q;
   logic [ADDR_W-1:0] wr_cnt_d;
   logic              last_slot;

   // Advance the write address on each sample, wrapping after the last slot
   always_comb begin
      last_slot = (wr_cnt_q == ADDR_W'(FRAME_LEN - 1));
      wr_cnt_d  = wr_cnt_q;
      if (sample_valid) begin
         wr_cnt_d = last_slot ? '0 : wr_cnt_q + ADDR_W'(1);
      end
   end

   // Address register; reset throws away any partial frame
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_cnt_q <= '0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign x_wen      = sample_valid;
   assign x_waddr    = wr_cnt_q;
   assign frame_full = sample_valid && last_slot;

endmodule

// File: rtl/lpc_frame_sequencer.sv
// Frame-level scheduler for the LPC analysis chain.
// Captures samples into a ping-pong buffer, then runs autocorrelation,
// Levinson-Durbin and the inverse filter in order for each full frame.
// Optional stage watchdog: define LPC_SEQ_WATCHDOG_EN (WDT_CYCLES sets the limit).
module lpc_frame_sequencer
   import lpc_pkg::*;
`ifdef LPC_SEQ_WATCHDOG_EN
#(
   parameter int WDT_CYCLES = 8192
)
`endif
(
   input logic                  clk,
   input logic                  reset,
   lpc_frame_sequencer_if.master bus
);

   logic frame_full;

   lpc_state_e       state_q, state_d;
   logic             x_wbank_q, x_wbank_d;
   logic             x_rbank_q, x_rbank_d;
   logic             acorr_start_q, acorr_start_d;
   logic             lev_start_q, lev_start_d;
   logic             ifilter_reset_q, ifilter_reset_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic [CNT_W-1:0] frame_count_q, frame_count_d;
   logic             overrun_q, overrun_d;

`ifdef LPC_SEQ_WATCHDOG_EN
   localparam int WDT_W = $clog2(WDT_CYCLES);
   logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
   logic             timeout_q, timeout_d;
`endif

   lpc_sample_writer u_writer (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (bus.sample_valid),
      .x_wen        (bus.x_wen),
      .x_waddr      (bus.x_waddr),
      .frame_full   (frame_full)
   );

   // Next-state logic: stage sequencing, bank swap, overrun and watchdog
   always_comb begin
      state_d       = state_q;
      x_wbank_d     = x_wbank_q;
      x_rbank_d     = x_rbank_q;
      acorr_start_d = 1'b0;
      lev_start_d   = 1'b0;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      overrun_d     = overrun_q;

      unique case (state_q)
         IDLE: begin
            if (frame_full) begin
               state_d       = ACORR;
               acorr_start_d = 1'b1;
               x_wbank_d     = ~x_wbank_q;
               x_rbank_d     = x_wbank_q;
            end
         end
         ACORR: begin
            if (bus.acorr_done) begin
               state_d     = LEV;
               lev_start_d = 1'b1;
            end
         end
         LEV: begin
            if (bus.lev_done) begin
               state_d = IFILT;
            end
         end
         IFILT: begin
            if (bus.ifilter_ready) begin
               state_d       = DONE;
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A frame finishing while the stages are busy is dropped; set beats clear
      if (frame_full && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end else if (bus.clear_overrun) begin
         overrun_d = 1'b0;
      end

`ifdef LPC_SEQ_WATCHDOG_EN
      wdt_cnt_d = '0;
      timeout_d = timeout_q;
      if (((state_q == ACORR) || (state_q == LEV) || (state_q == IFILT)) &&
          (state_d == state_q)) begin
         if (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
         end else begin
            wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
         end
      end
`endif

      busy_d          = (state_d != IDLE);
      ifilter_reset_d = (state_d != IFILT);
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= IDLE;
         x_wbank_q       <= 1'b0;
         x_rbank_q       <= 1'b1;
         acorr_start_q   <= 1'b0;
         lev_start_q     <= 1'b0;
         ifilter_reset_q <= 1'b1;
         busy_q          <= 1'b0;
         frame_done_q    <= 1'b0;
         frame_count_q   <= '0;
         overrun_q       <= 1'b0;
`ifdef LPC_SEQ_WATCHDOG_EN
         wdt_cnt_q       <= '0;
         timeout_q       <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         x_wbank_q       <= x_wbank_d;
         x_rbank_q       <= x_rbank_d;
         acorr_start_q   <= acorr_start_d;
         lev_start_q     <= lev_start_d;
         ifilter_reset_q <= ifilter_reset_d;
         busy_q          <= busy_d;
         frame_done_q    <= frame_done_d;
         frame_count_q   <= frame_count_d;
         overrun_q       <= overrun_d;
`ifdef LPC_SEQ_WATCHDOG_EN
         wdt_cnt_q       <= wdt_cnt_d;
         timeout_q       <= timeout_d;
`endif
      end
   end

   assign bus.x_wbank       = x_wbank_q;
   assign bus.x_rbank       = x_rbank_q;
   assign bus.acorr_start   = acorr_start_q;
   assign bus.lev_start     = lev_start_q;
   assign bus.ifilter_reset = ifilter_reset_q;
   assign bus.busy          = busy_q;
   assign bus.frame_done    = frame_done_q;
   assign bus.frame_count   = frame_count_q;
   assign bus.overrun       = overrun_q;
`ifdef LPC_SEQ_WATCHDOG_EN
   assign bus.timeout       = timeout_q;
`else
   assign bus.timeout       = 1'b0;
`endif

endmodule
